// File: rtl/solo_squash_pkg.sv
// Shared types and default parameters for the solo_squash pad conditioning logic.
//   sq_state_e         : reset sequencer state (hold game in reset / run)
//   SQ_DEBOUNCE_CYCLES : default number of consecutive differing samples to accept a button change
//   SQ_OE_DELAY        : default number of clean cycles before pad outputs are enabled
package solo_squash_pkg;

   typedef enum logic {
      StHold = 1'b0,
      StRun  = 1'b1
   } sq_state_e;

   localparam int unsigned SQ_DEBOUNCE_CYCLES = 16;
   localparam int unsigned SQ_OE_DELAY        = 8;

endpackage

// File: rtl/solo_squash_debouncer.sv
// Single-bit button conditioner: 2-flop synchroniser, debounce counter, press pulse.
// Ports:
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   raw_n_i   : raw asynchronous button, active-low, idle high
//   level_n_o : debounced button level, active-low
//   pressed_o : one-cycle pulse on an accepted high->low change
module solo_squash_debouncer
   import solo_squash_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = SQ_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_n_i,
   output logic level_n_o,
   output logic pressed_o
);

   localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            level_q, level_d;
   logic            pressed_q, pressed_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync;

   // Only the second synchroniser stage feeds the debounce logic.
   assign sync = sync_q[1];

   always_comb begin
      level_d   = level_q;
      pressed_d = 1'b0;
      cnt_d     = cnt_q;
      if (sync == level_q) begin
         // Any sample agreeing with the current level restarts the count.
         cnt_d = '0;
      end else if (cnt_q != CntLast) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         level_d   = sync;
         cnt_d     = '0;
         pressed_d = ~sync;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q    <= 2'b11;
         level_q   <= 1'b1;
         pressed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync_q    <= {sync_q[0], raw_n_i};
         level_q   <= level_d;
         pressed_q <= pressed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level_n_o = level_q;
   assign pressed_o = pressed_q;

endmodule

// File: rtl/solo_squash_io_conditioner.sv
// Conditioning stage between the Caravel pads and the solo_squash game core.
// Debounces active-low buttons, and sequences game reset and pad output enables so the
// pads stay hi-Z until reset has been released cleanly for OE_DELAY cycles.
// Ports:
//   clk           : sole clock
//   reset_n       : synchronous active-low reset
//   ext_reset     : raw asynchronous pad reset, active-high
//   buttons_raw_n : raw asynchronous buttons, active-low
//   buttons_n     : debounced button levels, active-low
//   pressed       : one-cycle pulse per debounced press
//   game_reset    : active-high reset to the game core
//   io_oeb        : pad output enables, active-low (1 = hi-Z)
module solo_squash_io_conditioner
   import solo_squash_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = SQ_DEBOUNCE_CYCLES,
   parameter int unsigned NUM_OUTPUTS     = 6,
   parameter int unsigned OE_DELAY        = SQ_OE_DELAY
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ext_reset,
   input  logic [NUM_BUTTONS-1:0] buttons_raw_n,
   output logic [NUM_BUTTONS-1:0] buttons_n,
   output logic [NUM_BUTTONS-1:0] pressed,
   output logic                   game_reset,
   output logic [NUM_OUTPUTS-1:0] io_oeb
);

   localparam int unsigned     DcntW    = $clog2(OE_DELAY + 1);
   localparam logic [DcntW-1:0] DcntLast = DcntW'(OE_DELAY - 1);

   // Button conditioning.
   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      solo_squash_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk_i    (clk),
         .rst_ni   (reset_n),
         .raw_n_i  (buttons_raw_n[i]),
         .level_n_o(buttons_n[i]),
         .pressed_o(pressed[i])
      );
   end

   // External reset synchroniser.
   logic [1:0] ext_sync_q;
   logic       ext_sync;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ext_sync_q <= 2'b00;
      end else begin
         ext_sync_q <= {ext_sync_q[0], ext_reset};
      end
   end

   assign ext_sync = ext_sync_q[1];

   // Reset sequencer.
   sq_state_e        state_q, state_d;
   logic [DcntW-1:0] dcnt_q, dcnt_d;

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         StHold: begin
            if (ext_sync) begin
               dcnt_d = '0;
            end else if (dcnt_q == DcntLast) begin
               state_d = StRun;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         StRun: begin
            if (ext_sync) begin
               state_d = StHold;
               dcnt_d  = '0;
            end
         end
         default: begin
            state_d = StHold;
            dcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StHold;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Driven straight from the state register so the pads never see a combinational glitch.
   assign game_reset = (state_q != StRun);
   assign io_oeb     = {NUM_OUTPUTS{game_reset}};

endmodule

// File: tb/tb_solo_squash_io_conditioner.sv
module tb_solo_squash_io_conditioner;

   localparam int NB       = 4;
   localparam int NO       = 6;
   localparam int DC       = 4;
   localparam int OED      = 8;
   localparam int MaxEdges = 4096;

   typedef logic [2*NB+NO:0] vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ext_reset;
   logic [NB-1:0] buttons_raw_n;
   logic [NB-1:0] buttons_n;
   logic [NB-1:0] pressed;
   logic          game_reset;
   logic [NO-1:0] io_oeb;

   solo_squash_io_conditioner #(
      .NUM_BUTTONS    (NB),
      .DEBOUNCE_CYCLES(DC),
      .NUM_OUTPUTS    (NO),
      .OE_DELAY       (OED)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ext_reset    (ext_reset),
      .buttons_raw_n(buttons_raw_n),
      .buttons_n    (buttons_n),
      .pressed      (pressed),
      .game_reset   (game_reset),
      .io_oeb       (io_oeb)
   );

   always #5 clk = ~clk;

   // Input history, one entry per rising edge.
   logic [NB-1:0] raw_h [MaxEdges];
   logic          rst_h [MaxEdges];
   logic          ext_h [MaxEdges];
   int            n_edges = 0;
   logic [NB-1:0] m_lvl;

   vec_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   mon_idx = 0;

   // Button value the debounce logic sees at edge k: raw two edges earlier, forced
   // idle-high if a reset edge cleared the synchroniser in between.
   function automatic logic [NB-1:0] btn_sync_at(input int k);
      if (k < 2) return '1;
      if (!rst_h[k-1] || !rst_h[k-2]) return '1;
      return raw_h[k-2];
   endfunction

   function automatic logic ext_sync_at(input int k);
      if (k < 2) return 1'b0;
      if (!rst_h[k-1] || !rst_h[k-2]) return 1'b0;
      return ext_h[k-2];
   endfunction

   function automatic logic clean_edge(input int k);
      return rst_h[k] && !ext_sync_at(k);
   endfunction

   // A button level flips once the last DC samples, none on a reset edge, all disagree
   // with it. The game runs once the last OED edges were all clean.
   task automatic model_step(input int k);
      logic [NB-1:0] prs;
      logic [NB-1:0] s;
      logic          gr;
      bit            acc;
      prs = '0;
      if (!rst_h[k]) begin
         m_lvl = '1;
      end else begin
         for (int b = 0; b < NB; b++) begin
            acc = (k >= DC - 1);
            for (int j = 0; j < DC; j++) begin
               if (acc) begin
                  if (!rst_h[k-j]) begin
                     acc = 1'b0;
                  end else begin
                     s = btn_sync_at(k - j);
                     if (s[b] == m_lvl[b]) acc = 1'b0;
                  end
               end
            end
            if (acc) begin
               prs[b]   = m_lvl[b];
               m_lvl[b] = ~m_lvl[b];
            end
         end
      end
      if (k < OED - 1) begin
         gr = 1'b1;
      end else begin
         gr = 1'b0;
         for (int j = 0; j < OED; j++) begin
            if (!clean_edge(k - j)) gr = 1'b1;
         end
      end
      exp_q.push_back({m_lvl, prs, gr, {NO{gr}}});
   endtask

   // Reference model: records inputs at each edge and queues the expected outputs.
   initial begin
      m_lvl = '1;
      forever begin
         @(posedge clk);
         if (n_edges < MaxEdges) begin
            raw_h[n_edges] = buttons_raw_n;
            rst_h[n_edges] = reset_n;
            ext_h[n_edges] = ext_reset;
            model_step(n_edges);
            n_edges++;
         end
      end
   end

   // Monitor: compares the registered outputs once per cycle, away from the rising edge.
   initial begin
      vec_t e;
      vec_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {buttons_n, pressed, game_reset, io_oeb};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs edge=%0d got={btn_n,pressed,grst,oeb}=%h expected=%h",
                        mon_idx, a, e);
            end
            mon_idx++;
         end
      end
   end

   // Watchdog: the stimulus must finish within a bounded number of cycles.
   initial begin
      #(MaxEdges * 10 * 2);
      $display("FAIL timeout: stimulus did not finish, total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      reset_n       = 1'b0;
      ext_reset     = 1'b0;
      buttons_raw_n = '1;
      cyc(3);
      // Reset state
      total++;
      if (buttons_n !== '1 || pressed !== '0 || game_reset !== 1'b1 || io_oeb !== '1) begin
         bad++;
         $display("FAIL reset state: btn_n=%b pressed=%b grst=%b oeb=%b",
                  buttons_n, pressed, game_reset, io_oeb);
      end
      // Reset release
      reset_n = 1'b1;
      cyc(12);
      // Clean press
      buttons_raw_n[2] = 1'b0;
      cyc(10);
      buttons_raw_n[2] = 1'b1;
      cyc(10);
      // Glitch rejection, then minimal accepted pulse
      buttons_raw_n[1] = 1'b0;
      cyc(3);
      buttons_raw_n[1] = 1'b1;
      cyc(10);
      buttons_raw_n[1] = 1'b0;
      cyc(4);
      buttons_raw_n[1] = 1'b1;
      cyc(12);
      // Bounce
      for (int i = 0; i < 10; i++) begin
         buttons_raw_n[0] = i[0];
         cyc(2);
      end
      buttons_raw_n[0] = 1'b0;
      cyc(10);
      buttons_raw_n[0] = 1'b1;
      cyc(10);
      // External reset, then a second pulse during hold
      ext_reset = 1'b1;
      cyc(1);
      ext_reset = 1'b0;
      cyc(5);
      ext_reset = 1'b1;
      cyc(1);
      ext_reset = 1'b0;
      cyc(16);
      // Reset mid-debounce
      buttons_raw_n[3] = 1'b0;
      cyc(4);
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      cyc(10);
      buttons_raw_n[3] = 1'b1;
      cyc(12);
      // Button accept coinciding with external reset taking effect
      buttons_raw_n[1] = 1'b0;
      cyc(3);
      ext_reset = 1'b1;
      cyc(1);
      ext_reset = 1'b0;
      cyc(16);
      buttons_raw_n[1] = 1'b1;
      cyc(20);
      // Randomised segments
      for (int i = 0; i < 300; i++) begin
         buttons_raw_n = NB'($urandom_range(0, (1 << NB) - 1));
         ext_reset     = ($urandom_range(0, 19) == 0);
         reset_n       = ($urandom_range(0, 39) != 0);
         cyc($urandom_range(1, 8));
      end
      reset_n   = 1'b1;
      ext_reset = 1'b0;
      cyc(2);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
